// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM states, parity modes and data-width clamping.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParEven = 2'd1,
    ParOdd  = 2'd2
  } parity_t;

  // Counts outside 5..9 fall back to a standard 8-bit frame.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] bits);
    logic [3:0] res;
    res = 4'd8;
    if (bits >= 4'd5 && bits <= 4'd9) res = bits;
    return res;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module uart_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words serialised with 5..9 data bits,
// optional even/odd parity and one or two stop bits, paced by an oversampling tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     tick_i,
  input  logic [MAX_DATA_BITS-1:0] data_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  input  logic [3:0]               data_bits_i,
  input  logic [1:0]               parity_i,
  input  logic                     stop_bits_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [CntW-1:0]          fifo_count_o
);

  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  tx_state_t                state_q, state_d;
  logic [TickW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     stop2_q, stop2_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;

  logic                     fifo_pop, fifo_empty, fifo_full;
  logic [MAX_DATA_BITS-1:0] fifo_rdata, mask;
  logic [3:0]               eff_bits;
  logic                     bit_end, load;

  uart_fifo #(
    .Width(MAX_DATA_BITS),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (tx_valid_i),
    .data_i (data_i),
    .pop_i  (fifo_pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count_o)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    bit_end    = 1'b0;
    load       = 1'b0;
    tx_d       = 1'b1;

    eff_bits = eff_data_bits(data_bits_i);
    for (int i = 0; i < MAX_DATA_BITS; i++) mask[i] = (4'(i) < eff_bits);

    if (state_q != StIdle && tick_i) begin
      if (tick_cnt_q == TickLast) begin
        tick_cnt_d = '0;
        bit_end    = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: load = !fifo_empty;
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == nbits_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == {3'b000, stop2_q}) begin
            done_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else             state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Configuration is captured with the word so mid-frame changes wait for the next pop.
    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = StStart;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = fifo_rdata;
      nbits_d    = eff_bits;
      par_en_d   = (parity_i == ParEven) || (parity_i == ParOdd);
      par_bit_d  = (^(fifo_rdata & mask)) ^ (parity_i == ParOdd);
      stop2_d    = stop_bits_i;
    end

    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != StIdle);
  assign frame_done_o = done_q;
  assign tx_ready_o   = !fifo_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, FIFO back-pressure, config capture, reset abort.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tick_i = 1'b0;
  logic [8:0] data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [3:0] data_bits_i = 4'd8;
  logic [1:0] parity_i = 2'd0;
  logic       stop_bits_i = 1'b0;
  logic       tx_o, busy_o, frame_done_o;
  logic [2:0] fifo_count_o;

  int checks = 0;
  int errors = 0;

  uart_tx_cfg #(
    .OVERSAMPLE(OS),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tick_i      (tick_i),
    .data_i      (data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .data_bits_i (data_bits_i),
    .parity_i    (parity_i),
    .stop_bits_i (stop_bits_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .fifo_count_o(fifo_count_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic sb);
    data_bits_i = nb;
    parity_i    = par;
    stop_bits_i = sb;
  endtask

  task automatic push(input logic [8:0] w);
    tx_valid_i = 1'b1;
    data_i     = w;
    @(posedge clk_i); #1;
    tx_valid_i = 1'b0;
  endtask

  // Push into an idle transmitter, then confirm the pop on the following edge.
  task automatic push_and_start(input string name, input logic [8:0] w);
    push(w);
    checks++;
    if (fifo_count_o !== 3'd1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: count=%0d busy=%b tx=%b, expected count=1 busy=0 tx=1",
               name, fifo_count_o, busy_o, tx_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (fifo_count_o !== 3'd0 || busy_o !== 1'b1 || tx_o !== 1'b0) begin
      errors++;
      $display("FAIL %s pop: count=%0d busy=%b tx=%b, expected count=0 busy=1 tx=0",
               name, fifo_count_o, busy_o, tx_o);
    end
  endtask

  // Frame already started: each tick is one cycle with tick high then one idle cycle.
  task automatic run_frame(input string name, input logic [15:0] exp, input int nbits,
                           input logic more);
    int done_at;
    int done_cnt;
    done_at  = -1;
    done_cnt = 0;
    for (int n = 1; n <= nbits * OS; n++) begin
      tick_i = 1'b1;
      @(posedge clk_i); #1;
      tick_i = 1'b0;
      if (frame_done_o) begin
        done_cnt++;
        done_at = n;
      end
      if (n % OS == OS / 2) begin
        checks++;
        if (tx_o !== exp[n / OS]) begin
          errors++;
          $display("FAIL %s bit%0d: tx=%b expected %b", name, n / OS, tx_o, exp[n / OS]);
        end
      end
      @(posedge clk_i); #1;
      if (frame_done_o) done_cnt++;
    end
    checks++;
    if (done_cnt != 1 || done_at != nbits * OS) begin
      errors++;
      $display("FAIL %s frame_done: pulses=%0d at tick %0d, expected 1 at tick %0d",
               name, done_cnt, done_at, nbits * OS);
    end
    checks++;
    if (tx_o !== !more || busy_o !== more) begin
      errors++;
      $display("FAIL %s end: tx=%b busy=%b, expected tx=%b busy=%b",
               name, tx_o, busy_o, !more, more);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    checks++;
    if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || busy_o !== 1'b0 ||
        frame_done_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset: tx=%b ready=%b busy=%b done=%b count=%0d, expected 1 1 0 0 0",
               tx_o, tx_ready_o, busy_o, frame_done_o, fifo_count_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_idle_tick();
    for (int i = 0; i < 5; i++) begin
      tick_i = 1'b1;
      @(posedge clk_i); #1;
      tick_i = 1'b0;
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_tick %0d: tx=%b busy=%b, expected tx=1 busy=0", i, tx_o, busy_o);
      end
    end
  endtask

  task automatic test_8n1();
    set_cfg(4'd8, 2'd0, 1'b0);
    push_and_start("8n1", 9'h0AA);
    run_frame("8n1", 16'h0354, 10, 1'b0);
  endtask

  task automatic test_7e1();
    set_cfg(4'd7, 2'd1, 1'b0);
    push_and_start("7e1", 9'h035);
    run_frame("7e1", 16'h026A, 10, 1'b0);
  endtask

  task automatic test_9o2();
    set_cfg(4'd9, 2'd2, 1'b1);
    push_and_start("9o2", 9'h0F3);
    run_frame("9o2", 16'h1DE6, 13, 1'b0);
  endtask

  // Out-of-range width and parity code 3 behave as plain 8N1.
  task automatic test_bad_cfg();
    set_cfg(4'd12, 2'd3, 1'b0);
    push_and_start("badcfg", 9'h1AA);
    run_frame("badcfg", 16'h0354, 10, 1'b0);
  endtask

  task automatic test_cfg_change();
    set_cfg(4'd8, 2'd0, 1'b0);
    push_and_start("cfgchg_a", 9'h0AA);
    set_cfg(4'd5, 2'd1, 1'b0);
    push(9'h1F3);
    run_frame("cfgchg_a", 16'h0354, 10, 1'b1);
    run_frame("cfgchg_b", 16'h00E6, 8, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words   [5];
    logic [2:0] exp_cnt [5];
    logic       exp_rdy [5];
    words   = '{8'h01, 8'h80, 8'h3C, 8'hFF, 8'h5A};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    set_cfg(4'd8, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tx_valid_i = 1'b1;
      data_i     = {1'b0, words[i]};
      @(posedge clk_i); #1;
      checks++;
      if (fifo_count_o !== exp_cnt[i] || tx_ready_o !== exp_rdy[i]) begin
        errors++;
        $display("FAIL b2b push%0d: count=%0d ready=%b, expected count=%0d ready=%b",
                 i, fifo_count_o, tx_ready_o, exp_cnt[i], exp_rdy[i]);
      end
    end
    tx_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("b2b_frame%0d", i), {6'b0, 1'b1, words[i], 1'b0}, 10, i < 4);
    end
    checks++;
    if (fifo_count_o !== 3'd0 || tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b drained: count=%0d ready=%b, expected count=0 ready=1",
               fifo_count_o, tx_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    set_cfg(4'd8, 2'd0, 1'b0);
    push_and_start("rstmid", 9'h0AA);
    push(9'h055);
    for (int n = 0; n < 40; n++) begin
      tick_i = 1'b1;
      @(posedge clk_i); #1;
      tick_i = 1'b0;
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid async: tx=%b busy=%b count=%0d ready=%b, expected 1 0 0 1",
               tx_o, busy_o, fifo_count_o, tx_ready_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick_i = 1'b1;
      @(posedge clk_i); #1;
      tick_i = 1'b0;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rstmid residual: activity seen after reset (flag=%b), expected none", bad);
    end
  endtask

  initial begin
    test_reset();
    test_idle_tick();
    test_8n1();
    test_7e1();
    test_9o2();
    test_bad_cfg();
    test_cfg_change();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
